// File: rtl/pipe_sum_tree.sv
// pipe_sum_tree: fully pipelined pairwise reduction tree, one tree level per clock.
// Sums N_IN signed lanes into one WORD_LEN word after LEVELS = log2(N_IN) cycles.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all levels
//   hold       1 = freeze every pipeline register
//   in_valid   in_data carries a vector this cycle
//   in_data    packed lanes, lane i at [i*WORD_LEN +: WORD_LEN]
//   out_valid  sum_out/out_sat valid this cycle
//   sum_out    reduced result (signed)
//   out_sat    saturation occurred somewhere in this result's tree (SAT_MODE=1 only)
// SAT_MODE=0 halves every level (floor), SAT_MODE=1 adds full scale with saturation.
module pipe_sum_tree #(
  parameter int unsigned WORD_LEN = 32,
  parameter int unsigned N_IN     = 8,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  input  logic                     in_valid,
  input  logic [N_IN*WORD_LEN-1:0] in_data,
  output logic                     out_valid,
  output logic [WORD_LEN-1:0]      sum_out,
  output logic                     out_sat
);

  localparam int unsigned LEVELS = $clog2(N_IN);

  for (genvar k = 1; k <= LEVELS; k++) begin : lvl
    localparam int unsigned NW = N_IN >> k;

    logic [WORD_LEN-1:0] src [2*NW];
    logic [2*NW-1:0]     src_sat;
    logic                src_valid;

    logic [WORD_LEN-1:0] nxt [NW];
    logic [NW-1:0]       nxt_sat;

    logic [WORD_LEN-1:0] word_q [NW];
    logic [NW-1:0]       sat_q;
    logic                valid_q;

    if (k == 1) begin : from_in
      always_comb begin
        for (int unsigned i = 0; i < 2*NW; i++) begin
          src[i] = in_data[i*WORD_LEN +: WORD_LEN];
        end
      end
      assign src_sat   = '0;
      assign src_valid = in_valid;
    end else begin : from_prev
      always_comb begin
        for (int unsigned i = 0; i < 2*NW; i++) begin
          src[i] = lvl[k-1].word_q[i];
        end
      end
      assign src_sat   = lvl[k-1].sat_q;
      assign src_valid = lvl[k-1].valid_q;
    end

    always_comb begin
      logic [WORD_LEN:0] s;
      logic              sat_here;
      for (int unsigned j = 0; j < NW; j++) begin
        s = {src[2*j][WORD_LEN-1], src[2*j]} + {src[2*j+1][WORD_LEN-1], src[2*j+1]};
        sat_here = 1'b0;
        if (SAT_MODE == 0) begin
          // Dropping the LSB of the extended sum is an exact floor(s/2).
          nxt[j] = s[WORD_LEN:1];
        end else begin
          nxt[j] = s[WORD_LEN-1:0];
          // Top two bits disagreeing means the sum left the WORD_LEN range.
          if (s[WORD_LEN:WORD_LEN-1] == 2'b01) begin
            nxt[j]   = {1'b0, {(WORD_LEN-1){1'b1}}};
            sat_here = 1'b1;
          end else if (s[WORD_LEN:WORD_LEN-1] == 2'b10) begin
            nxt[j]   = {1'b1, {(WORD_LEN-1){1'b0}}};
            sat_here = 1'b1;
          end
        end
        nxt_sat[j] = (SAT_MODE != 0) && (sat_here || src_sat[2*j] || src_sat[2*j+1]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < NW; i++) begin
          word_q[i] <= '0;
        end
        sat_q   <= '0;
        valid_q <= 1'b0;
      end else if (!hold) begin
        for (int unsigned i = 0; i < NW; i++) begin
          word_q[i] <= nxt[i];
        end
        sat_q   <= nxt_sat;
        valid_q <= src_valid;
      end
    end
  end

  assign out_valid = lvl[LEVELS].valid_q;
  assign sum_out   = lvl[LEVELS].word_q[0];
  assign out_sat   = lvl[LEVELS].sat_q[0];

endmodule

// File: tb/tb_pipe_sum_tree.sv
// Scoreboard bench for pipe_sum_tree: one SAT_MODE=0 and one SAT_MODE=1 instance
// share the stimulus; each has its own expected-result queue and monitor.
module tb_pipe_sum_tree;

  localparam int W      = 32;
  localparam int N      = 8;
  localparam int LEVELS = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           hold;
  logic           in_valid;
  logic [N*W-1:0] in_data;
  logic           out_valid0, out_valid1;
  logic [W-1:0]   sum_out0, sum_out1;
  logic           out_sat0, out_sat1;

  pipe_sum_tree #(.WORD_LEN(W), .N_IN(N), .SAT_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid0), .sum_out(sum_out0), .out_sat(out_sat0));

  pipe_sum_tree #(.WORD_LEN(W), .N_IN(N), .SAT_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid1), .sum_out(sum_out1), .out_sat(out_sat1));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         sat;
    int           due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks   = 0;
  int failures = 0;
  int adv      = 0;   // count of edges at which the pipeline advances
  int last0    = -1;
  int last1    = -1;

  always @(posedge clk) if (rst_n && !hold) adv <= adv + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitors: pop once per advancing edge on which out_valid is seen.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid0 && adv != last0) begin
      last0 = adv;
      if (q0.size() == 0) fail_now("m0_unexpected_out_valid");
      else begin
        e = q0.pop_front();
        chk("m0_sum", sum_out0, e.sum);
        chk("m0_sat", {31'd0, out_sat0}, {31'd0, e.sat});
        chk("m0_latency", adv, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid1 && adv != last1) begin
      last1 = adv;
      if (q1.size() == 0) fail_now("m1_unexpected_out_valid");
      else begin
        e = q1.pop_front();
        chk("m1_sum", sum_out1, e.sum);
        chk("m1_sat", {31'd0, out_sat1}, {31'd0, e.sat});
        chk("m1_latency", adv, e.due);
      end
    end
  end

  // Called #1 after the accepting edge.
  task automatic push(input logic [W-1:0] e0, input logic [W-1:0] e1, input logic s1);
    exp_t e;
    e.due = adv + LEVELS - 1;
    e.sum = e0; e.sat = 1'b0; q0.push_back(e);
    e.sum = e1; e.sat = s1;   q1.push_back(e);
  endtask

  task automatic issue(input logic [N*W-1:0] d, input logic [W-1:0] e0,
                       input logic [W-1:0] e1, input logic s1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    push(e0, e1, s1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk); #1;
    end
    if (q0.size() != 0 || q1.size() != 0) fail_now("drain_timeout_missing_results");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, {30'd0, out_valid1, out_valid0}, 32'd0);
    chk({tag, "_sum0"}, sum_out0, 32'd0);
    chk({tag, "_sum1"}, sum_out1, 32'd0);
    chk({tag, "_sat"}, {30'd0, out_sat1, out_sat0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; hold = 1'b0; in_valid = 1'b0; in_data = '0;
    #3;
    chk_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic vectors (SAT_MODE=0 result, SAT_MODE=1 result, SAT_MODE=1 sat).
    issue({8{32'h0000_0100}}, 32'h0000_0100, 32'h0000_0800, 1'b0);
    idle();
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    issue({4{32'h0, 32'hFFFF_FFFF}}, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0);
    issue({8{32'h1}}, 32'h1, 32'h8, 1'b0);
    issue({8{32'h7FFF_FFFF}}, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    issue({8{32'h8000_0000}}, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue({32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 32'd4, 32'd36, 1'b0);
    idle();
    drain();

    // 16 back-to-back vectors, lane0 = n.
    for (int n = 0; n < 16; n++) begin
      logic [W-1:0] nv;
      nv = W'(n);
      issue({224'd0, nv}, nv >> 3, nv, 1'b0);
    end
    idle();
    drain();

    // A, B accepted, hold for 2 edges with C presented, then C accepted.
    issue({8{32'h10}}, 32'h10, 32'h80, 1'b0);
    issue({192'd0, 32'd1, 32'h7FFF_FFFF}, 32'h1000_0000, 32'h7FFF_FFFF, 1'b1);
    hold = 1'b1;
    in_data = {8{32'hFFFF_FFFE}};
    @(posedge clk); #1; @(posedge clk); #1;
    hold = 1'b0;
    @(posedge clk); #1;
    push(32'hFFFF_FFFE, 32'hFFFF_FFF0, 1'b0);
    idle();
    drain();

    // A vector presented only during hold must never appear.
    hold = 1'b1; in_valid = 1'b1; in_data = {8{32'h55}};
    @(posedge clk); #1; @(posedge clk); #1;
    hold = 1'b0;
    idle();
    repeat (6) begin @(posedge clk); #1; end
    chk("hold_drop_no_output", {31'd0, out_valid0 | out_valid1}, 32'd0);

    // Reset with three vectors in flight.
    issue({8{32'h3}}, 32'h3, 32'h18, 1'b0);
    issue({8{32'h3}}, 32'h3, 32'h18, 1'b0);
    issue({8{32'h3}}, 32'h3, 32'h18, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk_zero("after_reset_idle");

    issue({8{32'h1}}, 32'h1, 32'h8, 1'b0);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
